// File: rtl/cal_pkg.sv
// Shared calendar definitions for the date counter and the day-of-week calculator.
// Holds the field widths, the reset date, the year limit and the month-length table.
package cal_pkg;

  localparam int DAY_W   = 5;
  localparam int MONTH_W = 4;
  localparam int YEAR_W  = 13;

  localparam logic [YEAR_W-1:0] YEAR_MAX = 13'd8191;

  // 01-01-2000 is a Saturday, the day-of-week calculator's anchor
  localparam logic [DAY_W-1:0]   RESET_DAY   = 5'd1;
  localparam logic [MONTH_W-1:0] RESET_MONTH = 4'd1;
  localparam logic [YEAR_W-1:0]  RESET_YEAR  = 13'd2000;

  localparam logic [DAY_W-1:0] MONTH_DAYS [0:11] = '{
    5'd31, 5'd28, 5'd31, 5'd30, 5'd31, 5'd30,
    5'd31, 5'd31, 5'd30, 5'd31, 5'd30, 5'd31
  };

  // Returns 0 for a month outside 1..12 so callers can use it as a validity bound
  function automatic logic [DAY_W-1:0] days_in_month(input logic [MONTH_W-1:0] month,
                                                     input logic leap);
    logic [DAY_W-1:0] d;
    d = '0;
    if (month >= 4'd1 && month <= 4'd12) begin
      d = MONTH_DAYS[month - 4'd1];
      if (month == 4'd2 && leap) d = 5'd29;
    end
    return d;
  endfunction

endpackage

// File: rtl/leap_year.sv
// Combinational Gregorian leap-year test on a 13-bit year.
module leap_year
  import cal_pkg::*;
(
  input  logic [YEAR_W-1:0] year,
  output logic              leap
);

  logic div4;
  logic div100;
  logic div400;

  assign div4   = (year % 13'd4)   == 13'd0;
  assign div100 = (year % 13'd100) == 13'd0;
  assign div400 = (year % 13'd400) == 13'd0;

  assign leap = div400 || (div4 && !div100);

endmodule

// File: rtl/date_counter.sv
// Registered calendar date with validated load, one-day tick advance and a sticky
// overflow flag at 31-12-8191. Priority per edge: reset, then load, then tick.
module date_counter
  import cal_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [DAY_W-1:0]   load_day,
  input  logic [MONTH_W-1:0] load_month,
  input  logic [YEAR_W-1:0]  load_year,
  input  logic               tick,
  output logic [DAY_W-1:0]   day,
  output logic [MONTH_W-1:0] month,
  output logic [YEAR_W-1:0]  year,
  output logic [DAY_W-1:0]   mdays,
  output logic               upd,
  output logic               load_err,
  output logic               ovf
);

  logic                leap_cur;
  logic                leap_load;
  logic                load_ok;
  logic                at_max;
  logic [DAY_W-1:0]    load_mdays;
  logic [DAY_W-1:0]    next_day;
  logic [MONTH_W-1:0]  next_month;
  logic [YEAR_W-1:0]   next_year;

  leap_year u_leap_cur (
    .year (year),
    .leap (leap_cur)
  );

  leap_year u_leap_load (
    .year (load_year),
    .leap (leap_load)
  );

  assign mdays      = days_in_month(month, leap_cur);
  assign load_mdays = days_in_month(load_month, leap_load);

  // An out-of-range month yields load_mdays of 0, which fails the day bound too
  assign load_ok = (load_year != '0) &&
                   (load_day != '0) &&
                   (load_day <= load_mdays);

  assign at_max = (day == 5'd31) && (month == 4'd12) && (year == YEAR_MAX);

  always_comb begin
    next_day   = day + 5'd1;
    next_month = month;
    next_year  = year;
    if (day >= mdays) begin
      next_day = 5'd1;
      if (month < 4'd12) begin
        next_month = month + 4'd1;
      end else begin
        next_month = 4'd1;
        next_year  = year + 13'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      day      <= RESET_DAY;
      month    <= RESET_MONTH;
      year     <= RESET_YEAR;
      upd      <= 1'b0;
      load_err <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      upd      <= 1'b0;
      load_err <= 1'b0;
      if (load) begin
        if (load_ok) begin
          day   <= load_day;
          month <= load_month;
          year  <= load_year;
          upd   <= 1'b1;
          ovf   <= 1'b0;
        end else begin
          load_err <= 1'b1;
        end
      end else if (tick) begin
        // The last representable day refuses to roll over instead of wrapping to year 0
        if (at_max) begin
          ovf <= 1'b1;
        end else begin
          day   <= next_day;
          month <= next_month;
          year  <= next_year;
          upd   <= 1'b1;
        end
      end
    end
  end

endmodule
